load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 34 +++
 rtl/lsu_byte_lane.sv | 58 +++++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcodes, access sizes, FSM states.
package load_store_unit_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } lsu_state_e;

  // Legal size code and natural alignment for that size.
  function automatic logic access_ok(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3_e'(funct3))
      F3_B, F3_BU: access_ok = 1'b1;
      F3_H, F3_HU: access_ok = ~addr_lo[0];
      F3_W:        access_ok = (addr_lo == 2'b00);
      default:     access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module lsu_byte_lane
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Store side: lane enables and replicated write data by access size.
  always_comb begin
    sel   = '0;
    wdata = '0;
    case (funct3[1:0])
      2'b00: begin
        sel   = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        sel   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        sel   = '1;
        wdata = store_data;
      end
    endcase
  end

  // Load side: pick the addressed byte/half and sign- or zero-extend it.
  always_comb begin
    lane_byte   = '0;
    lane_half   = '0;
    load_result = '0;
    case (addr_lo)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3_e'(funct3))
      F3_B:    load_result = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_result = {24'b0, lane_byte};
      F3_H:    load_result = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_result = {16'b0, lane_half};
      default: load_result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory instruction at a time, runs a single
// bus access with timeout, and returns extended load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [3:0]  bus_sel,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        fault
);

  localparam int unsigned   CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  lsu_state_e    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   addr_q, data_q;
  logic [2:0]    funct3_q;
  logic          capture, ld_capture, fault_next;
  logic          is_load_op, is_store_op, mem_op;
  logic [31:0]   req_addr;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_wdata, lane_load;

  assign is_load_op  = (opcode == OPC_LOAD);
  assign is_store_op = (opcode == OPC_STORE);
  assign mem_op      = start & (is_load_op | is_store_op);
  assign req_addr    = is_store_op ? write_address : read_address;

  lsu_byte_lane u_lane (
    .addr_lo     (addr_q[1:0]),
    .funct3      (funct3_q),
    .store_data  (data_q),
    .rdata       (bus_rdata),
    .sel         (lane_sel),
    .wdata       (lane_wdata),
    .load_result (lane_load)
  );

  // FSM state and timeout counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Captured instruction fields, registered load result and fault pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q    <= '0;
      data_q    <= '0;
      funct3_q  <= '0;
      load_data <= '0;
      fault     <= 1'b0;
    end else begin
      fault <= fault_next;
      if (capture) begin
        addr_q   <= req_addr;
        funct3_q <= funct3;
        data_q   <= store_data;
      end
      if (ld_capture) begin
        load_data <= lane_load;
      end
    end
  end

  // Next state, timeout handling and bus/pipeline outputs.
  // bus_ack is tested before the timeout compare so an ack on the last
  // allowed cycle still completes the access.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    ld_capture = 1'b0;
    fault_next = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_ren    = 1'b0;
    bus_wen    = 1'b0;
    bus_sel    = '0;
    stall      = 1'b0;
    load_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_next = '0;
        stall    = mem_op;
        if (mem_op) begin
          if (access_ok(funct3, req_addr[1:0])) begin
            capture    = 1'b1;
            state_next = is_load_op ? ST_READ : ST_WRITE;
          end else begin
            fault_next = 1'b1;
          end
        end
      end
      ST_READ, ST_WRITE: begin
        stall    = 1'b1;
        bus_addr = {addr_q[31:2], 2'b00};
        if (state == ST_READ) begin
          bus_ren = 1'b1;
          bus_sel = '1;
        end else begin
          bus_wen   = 1'b1;
          bus_sel   = lane_sel;
          bus_wdata = lane_wdata;
        end
        if (bus_ack) begin
          ld_capture = (state == ST_READ);
          state_next = (state == ST_READ) ? ST_DONE : ST_IDLE;
        end else if (cnt == CNT_MAX) begin
          fault_next = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        load_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
